reg_read_stage: RTL and testbench

- Operand-fetch pipeline stage of the RV32I multicycle pipeline. It sits between decode and execute, and is the reading end of the register-file / bypass interface that writeback drives.
- Accepts a decoded instruction, reads rs1/rs2 from the register file, and overrides stale values with the execute bypass and the writeback bypass.
- Stalls on a pending producer whose value is not yet available on any bypass. It snoops both bypasses every held cycle until both operands resolve, then hands them to execute.
- Uses the same beforePipReadyToSend / nextPipReadyToRcv / startSig handshake as every other pipe stage.

---
 rtl/reg_read_stage_pkg.sv | 16 +
 rtl/reg_read_stage_operand_resolve.sv | 55 +++++
 rtl/reg_read_stage.sv | 122 ++++++++++++
 tb/tb_reg_read_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_read_stage_pkg.sv
// Shared pipeline definitions: datapath widths, handshake state encodings
// common to every pipe stage, and the "no bypass" register index.
package reg_read_stage_pkg;

    localparam int XLEN    = 32;
    localparam int REG_IDX = 5;

    localparam logic [REG_IDX-1:0] NO_BYPASS = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_BEF = 2'b01,
        HOLD     = 2'b10
    } pipe_state_e;

endpackage

// File: rtl/reg_read_stage_operand_resolve.sv
// Resolves one source operand against x0, the execute bypass, a pending
// producer, the writeback bypass and the register file; holds it once ready.
module operand_resolve #(
    parameter int XLEN    = reg_read_stage_pkg::XLEN,
    parameter int REG_IDX = reg_read_stage_pkg::REG_IDX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               snoop,
    input  logic [REG_IDX-1:0] idx,
    input  logic [REG_IDX-1:0] bp_ex_idx,
    input  logic [XLEN-1:0]    bp_ex_val,
    input  logic [REG_IDX-1:0] pend_idx,
    input  logic [REG_IDX-1:0] bp_wb_idx,
    input  logic [XLEN-1:0]    bp_wb_val,
    input  logic [XLEN-1:0]    rf_val,
    output logic [XLEN-1:0]    val,
    output logic               rdy
);
    import reg_read_stage_pkg::*;

    logic [XLEN-1:0] res_val;
    logic            res_rdy;

    // Execute bypass is checked before the pending producer so it wins on a tie.
    always_comb begin
        res_val = rf_val;
        res_rdy = 1'b1;
        if (idx == NO_BYPASS) begin
            res_val = '0;
        end else if (idx == bp_ex_idx) begin
            res_val = bp_ex_val;
        end else if (idx == pend_idx) begin
            res_val = val;
            res_rdy = 1'b0;
        end else if (idx == bp_wb_idx) begin
            res_val = bp_wb_val;
        end
    end

    // A resolved operand is frozen until the next load; later writebacks are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
            rdy <= 1'b0;
        end else if (load || (snoop && !rdy)) begin
            rdy <= res_rdy;
            if (res_rdy) begin
                val <= res_val;
            end
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// Operand-fetch stage between decode and execute: reads rs1/rs2, applies
// execute/writeback bypasses, and stalls on pending producers.
module reg_read_stage #(
    parameter int XLEN      = reg_read_stage_pkg::XLEN,
    parameter int REG_IDX   = reg_read_stage_pkg::REG_IDX,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startSig,
    input  logic                 beforePipReadyToSend,
    input  logic                 nextPipReadyToRcv,
    output logic                 curPipReadyToRcv,
    output logic                 curPipReadyToSend,
    input  logic [REG_IDX-1:0]   dec_rs1_idx,
    input  logic [REG_IDX-1:0]   dec_rs2_idx,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    output logic [REG_IDX-1:0]   rf_rd_idx1,
    output logic [REG_IDX-1:0]   rf_rd_idx2,
    input  logic [XLEN-1:0]      rf_rd_val1,
    input  logic [XLEN-1:0]      rf_rd_val2,
    input  logic [REG_IDX-1:0]   bp_ex_idx,
    input  logic [XLEN-1:0]      bp_ex_val,
    input  logic [REG_IDX-1:0]   pend_idx,
    input  logic [REG_IDX-1:0]   bp_wb_idx,
    input  logic [XLEN-1:0]      bp_wb_val,
    output logic [XLEN-1:0]      op1_val,
    output logic [XLEN-1:0]      op2_val,
    output logic [REG_IDX-1:0]   op_rs1_idx,
    output logic [REG_IDX-1:0]   op_rs2_idx,
    output logic [PAYLOAD_W-1:0] op_payload
);
    import reg_read_stage_pkg::*;

    pipe_state_e          state;
    logic [REG_IDX-1:0]   rs1_q;
    logic [REG_IDX-1:0]   rs2_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 rdy1;
    logic                 rdy2;
    logic                 accept;
    logic                 snoop;
    logic                 handoff;

    assign curPipReadyToSend = (state == HOLD) && rdy1 && rdy2;
    assign handoff           = curPipReadyToSend && nextPipReadyToRcv;
    assign curPipReadyToRcv  = (state == WAIT_BEF) || handoff;

    // startSig forces an accept whenever decode has something, regardless of readiness.
    assign accept = startSig ? beforePipReadyToSend
                             : (curPipReadyToRcv && beforePipReadyToSend);
    assign snoop  = (state == HOLD) && !startSig;

    assign rf_rd_idx1 = accept ? dec_rs1_idx : rs1_q;
    assign rf_rd_idx2 = accept ? dec_rs2_idx : rs2_q;

    assign op_rs1_idx = rs1_q;
    assign op_rs2_idx = rs2_q;
    assign op_payload = payload_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            payload_q <= '0;
        end else begin
            if (accept) begin
                rs1_q     <= dec_rs1_idx;
                rs2_q     <= dec_rs2_idx;
                payload_q <= dec_payload;
            end
            if (startSig) begin
                state <= beforePipReadyToSend ? HOLD : WAIT_BEF;
            end else begin
                case (state)
                    IDLE:     state <= IDLE;
                    WAIT_BEF: state <= beforePipReadyToSend ? HOLD : WAIT_BEF;
                    HOLD: begin
                        if (handoff) begin
                            state <= beforePipReadyToSend ? HOLD : WAIT_BEF;
                        end
                    end
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    operand_resolve #(.XLEN(XLEN), .REG_IDX(REG_IDX)) u_rs1 (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .snoop     (snoop),
        .idx       (rf_rd_idx1),
        .bp_ex_idx (bp_ex_idx),
        .bp_ex_val (bp_ex_val),
        .pend_idx  (pend_idx),
        .bp_wb_idx (bp_wb_idx),
        .bp_wb_val (bp_wb_val),
        .rf_val    (rf_rd_val1),
        .val       (op1_val),
        .rdy       (rdy1)
    );

    operand_resolve #(.XLEN(XLEN), .REG_IDX(REG_IDX)) u_rs2 (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .snoop     (snoop),
        .idx       (rf_rd_idx2),
        .bp_ex_idx (bp_ex_idx),
        .bp_ex_val (bp_ex_val),
        .pend_idx  (pend_idx),
        .bp_wb_idx (bp_wb_idx),
        .bp_wb_val (bp_wb_val),
        .rf_val    (rf_rd_val2),
        .val       (op2_val),
        .rdy       (rdy2)
    );

endmodule

// File: tb/tb_reg_read_stage.sv
// Scenario bench for reg_read_stage with a scoreboard of expected handoffs.
module tb_reg_read_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        startSig;
    logic        bef;
    logic        nxt;
    logic        rcv;
    logic        snd;
    logic [4:0]  rs1, rs2;
    logic [63:0] payload;
    logic [4:0]  rf_rd_idx1, rf_rd_idx2;
    logic [31:0] rf_rd_val1, rf_rd_val2;
    logic [4:0]  bp_ex_idx, pend_idx, bp_wb_idx;
    logic [31:0] bp_ex_val, bp_wb_val;
    logic [31:0] op1_val, op2_val;
    logic [4:0]  op_rs1_idx, op_rs2_idx;
    logic [63:0] op_payload;

    logic [31:0] rf [32];

    typedef struct {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [63:0] pl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    always #5 clk = ~clk;

    assign rf_rd_val1 = rf[rf_rd_idx1];
    assign rf_rd_val2 = rf[rf_rd_idx2];

    reg_read_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .startSig             (startSig),
        .beforePipReadyToSend (bef),
        .nextPipReadyToRcv    (nxt),
        .curPipReadyToRcv     (rcv),
        .curPipReadyToSend    (snd),
        .dec_rs1_idx          (rs1),
        .dec_rs2_idx          (rs2),
        .dec_payload          (payload),
        .rf_rd_idx1           (rf_rd_idx1),
        .rf_rd_idx2           (rf_rd_idx2),
        .rf_rd_val1           (rf_rd_val1),
        .rf_rd_val2           (rf_rd_val2),
        .bp_ex_idx            (bp_ex_idx),
        .bp_ex_val            (bp_ex_val),
        .pend_idx             (pend_idx),
        .bp_wb_idx            (bp_wb_idx),
        .bp_wb_val            (bp_wb_val),
        .op1_val              (op1_val),
        .op2_val              (op2_val),
        .op_rs1_idx           (op_rs1_idx),
        .op_rs2_idx           (op_rs2_idx),
        .op_payload           (op_payload)
    );

    // Execute side: every handoff must match the oldest expected instruction.
    always @(negedge clk) begin
        if (!rst && snd && nxt) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL handoff_unexpected op1=%h op2=%h payload=%h expected none", op1_val, op2_val, op_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                if (op1_val !== e.v1 || op2_val !== e.v2 || op_payload !== e.pl ||
                    op_rs1_idx !== e.r1 || op_rs2_idx !== e.r2) begin
                    errors++;
                    $display("FAIL handoff got rs=%0d/%0d op=%h/%h pl=%h expected rs=%0d/%0d op=%h/%h pl=%h",
                             op_rs1_idx, op_rs2_idx, op1_val, op2_val, op_payload,
                             e.r1, e.r2, e.v1, e.v2, e.pl);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        bp_ex_idx = 0; bp_ex_val = 0;
        pend_idx  = 0;
        bp_wb_idx = 0; bp_wb_val = 0;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [63:0] pl,
                         input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        rs1 = r1; rs2 = r2; payload = pl; bef = 1'b1;
        e.r1 = r1; e.r2 = r2; e.v1 = v1; e.v2 = v2; e.pl = pl;
        sb.push_back(e);
    endtask

    task automatic drain();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (snd !== 1'b0 || rcv !== 1'b0 || op1_val !== 0 || op2_val !== 0 || op_payload !== 0) begin
            errors++;
            $display("FAIL reset snd=%b rcv=%b op1=%h op2=%h pl=%h expected all zero", snd, rcv, op1_val, op2_val, op_payload);
        end
        nxt = 1'b1;
        tick();
        checks++;
        if (rcv !== 1'b0 || snd !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays rcv=%b snd=%b expected 0/0", rcv, snd);
        end
        nxt = 1'b0;
    endtask

    task automatic test_basic();
        startSig = 1'b1;
        issue(5'd3, 5'd4, 64'hA000_0000_0000_0001, 32'h11, 32'h22);
        tick();
        startSig = 1'b0; bef = 1'b0;
        checks++;
        if (snd !== 1'b1 || op1_val !== 32'h11 || op2_val !== 32'h22) begin
            errors++;
            $display("FAIL basic snd=%b op1=%h op2=%h expected 1 11 22", snd, op1_val, op2_val);
        end
        drain();
        checks++;
        if (snd !== 1'b0 || rcv !== 1'b1) begin
            errors++;
            $display("FAIL wait_bef snd=%b rcv=%b expected 0 1", snd, rcv);
        end
    endtask

    task automatic test_bypass();
        bp_wb_idx = 5; bp_wb_val = 32'hAA;
        issue(5'd5, 5'd4, 64'hA000_0000_0000_0002, 32'hAA, 32'h22);
        tick();
        bef = 1'b0; clear_bypass();
        checks++;
        if (snd !== 1'b1 || op1_val !== 32'hAA) begin
            errors++;
            $display("FAIL wb_bypass snd=%b op1=%h expected 1 aa", snd, op1_val);
        end
        drain();
        bp_wb_idx = 5; bp_wb_val = 32'hAA;
        bp_ex_idx = 5; bp_ex_val = 32'hBB;
        issue(5'd5, 5'd4, 64'hA000_0000_0000_0003, 32'hBB, 32'h22);
        tick();
        bef = 1'b0; clear_bypass();
        checks++;
        if (snd !== 1'b1 || op1_val !== 32'hBB) begin
            errors++;
            $display("FAIL ex_over_wb snd=%b op1=%h expected 1 bb", snd, op1_val);
        end
        drain();
    endtask

    task automatic test_pending();
        pend_idx = 7;
        issue(5'd3, 5'd7, 64'hA000_0000_0000_0004, 32'h11, 32'hC0);
        tick();
        bef = 1'b0;
        bp_wb_idx = 7; bp_wb_val = 32'h99;
        nxt = 1'b1;
        checks++;
        if (snd !== 1'b0) begin
            errors++;
            $display("FAIL pend_cycle1 snd=%b expected 0", snd);
        end
        tick();
        checks++;
        if (snd !== 1'b0) begin
            errors++;
            $display("FAIL pend_cycle2 snd=%b expected 0", snd);
        end
        clear_bypass();
        bp_ex_idx = 7; bp_ex_val = 32'hC0;
        nxt = 1'b0;
        tick();
        clear_bypass();
        checks++;
        if (snd !== 1'b1 || op2_val !== 32'hC0 || op1_val !== 32'h11) begin
            errors++;
            $display("FAIL pend_resolve snd=%b op1=%h op2=%h expected 1 11 c0", snd, op1_val, op2_val);
        end
        drain();
        pend_idx = 9; bp_ex_idx = 9; bp_ex_val = 32'h3C;
        issue(5'd9, 5'd4, 64'hA000_0000_0000_0005, 32'h3C, 32'h22);
        tick();
        bef = 1'b0; clear_bypass();
        checks++;
        if (snd !== 1'b1 || op1_val !== 32'h3C) begin
            errors++;
            $display("FAIL ex_over_pend snd=%b op1=%h expected 1 3c", snd, op1_val);
        end
        drain();
    endtask

    task automatic test_zero_and_freeze();
        rf[0] = 32'hFFFF;
        bp_ex_idx = 0; bp_ex_val = 32'h1234;
        issue(5'd0, 5'd3, 64'hA000_0000_0000_0006, 32'h0, 32'h11);
        tick();
        bef = 1'b0; clear_bypass();
        checks++;
        if (snd !== 1'b1 || op1_val !== 32'h0 || op2_val !== 32'h11) begin
            errors++;
            $display("FAIL x0_zero snd=%b op1=%h op2=%h expected 1 0 11", snd, op1_val, op2_val);
        end
        drain();
        issue(5'd3, 5'd4, 64'hA000_0000_0000_0007, 32'h11, 32'h22);
        tick();
        bef = 1'b0;
        bp_wb_idx = 3; bp_wb_val = 32'h55;
        tick();
        tick();
        clear_bypass();
        checks++;
        if (snd !== 1'b1 || op1_val !== 32'h11) begin
            errors++;
            $display("FAIL freeze snd=%b op1=%h expected 1 11", snd, op1_val);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = pops;
        nxt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] a, b;
            a = 5'(10 + i);
            b = (i == 2) ? a : 5'(20 + i);
            issue(a, b, 64'hB000_0000_0000_0000 | 64'(i), 32'h1000 + 32'(a), 32'h1000 + 32'(b));
            tick();
            checks++;
            if (snd !== 1'b1) begin
                errors++;
                $display("FAIL stream_send i=%0d snd=%b expected 1", i, snd);
            end
        end
        bef = 1'b0;
        tick();
        nxt = 1'b0;
        checks++;
        if (pops - start_pops != 4) begin
            errors++;
            $display("FAIL stream_count handoffs=%0d expected 4", pops - start_pops);
        end
    endtask

    task automatic test_hold_reset();
        nxt = 1'b0;
        issue(5'd3, 5'd4, 64'hC000_0000_0000_0001, 32'h11, 32'h22);
        tick();
        bef = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snd !== 1'b1 || op1_val !== 32'h11 || op2_val !== 32'h22 ||
                op_payload !== 64'hC000_0000_0000_0001) begin
                errors++;
                $display("FAIL hold_stable i=%0d snd=%b op1=%h op2=%h pl=%h expected 1 11 22 c000000000000001",
                         i, snd, op1_val, op2_val, op_payload);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks++;
        if (snd !== 1'b0 || rcv !== 1'b0 || op1_val !== 0 || op2_val !== 0 ||
            op_payload !== 0 || op_rs1_idx !== 0 || op_rs2_idx !== 0) begin
            errors++;
            $display("FAIL mid_reset snd=%b rcv=%b op1=%h op2=%h pl=%h rs=%0d/%0d expected all zero",
                     snd, rcv, op1_val, op2_val, op_payload, op_rs1_idx, op_rs2_idx);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'h1000 + k;
        rf[3] = 32'h11; rf[4] = 32'h22; rf[5] = 32'h01; rf[7] = 32'h07;
        rst = 1'b1; startSig = 1'b0; bef = 1'b0; nxt = 1'b0;
        rs1 = 0; rs2 = 0; payload = 0;
        clear_bypass();

        test_reset();
        test_basic();
        test_bypass();
        test_pending();
        test_zero_and_freeze();
        test_back_to_back();
        test_hold_reset();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover entries=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
